fifo_wr_ctrl: RTL and testbench

// - Write-side pointer/flag controller of the async FIFO; upstream counterpart of the read-side controller.
// - Accepts producer writes and drives memory write address/enable.
// - Publishes a Gray write pointer to the read domain.
// - Brings the read-domain Gray pointer in through a 2-flop synchronizer and derives full.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ptr_sync.sv | 27 ++
 rtl/fifo_wr_ctrl.sv | 94 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and Gray/binary conversions.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int unsigned FIFO_ADDR_W = 3;

  // Conversion helpers work on a wide vector so any pointer width can zero-extend into them.
  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [FIFO_ADDR_W:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zero bits of a zero-extended Gray value leave the low binary bits unaffected.
  function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
    ptr_wide_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer crossing into the local clock domain.
// Synchronous active-high reset clears both stages.
module fifo_ptr_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [WIDTH-1:0] stage1_q;
  logic [WIDTH-1:0] stage2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_in;
      stage2_q <= stage1_q;
    end
  end

  assign d_out = stage2_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller of the async FIFO: write address/enable, Gray write
// pointer, synchronized read pointer and full flag. FIFO_WR_ALMOST_FULL_EN adds almost_full.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = FIFO_ADDR_W,
  parameter int unsigned ALMOST_FULL_TH = 6
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  wclken,
  output logic [ADDR_WIDTH:0]   gray_wr_ptr,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                  full,
  output logic                  almost_full
`else
  output logic                  full
`endif
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;

  if (ADDR_WIDTH < 2) begin : g_aw_check
    $error("ADDR_WIDTH must be at least 2");
  end
  if (ALMOST_FULL_TH > (2 ** ADDR_WIDTH)) begin : g_th_check
    $error("ALMOST_FULL_TH exceeds FIFO depth");
  end

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] gray_wr_ptr_q;
  logic [PtrW-1:0] wr_ptr_next;
  logic [PtrW-1:0] gray_wr_ptr_next;
  logic [PtrW-1:0] rq2;
  logic [PtrW-1:0] full_match;

  fifo_ptr_sync #(
    .WIDTH (PtrW)
  ) u_rd_ptr_sync (
    .clk   (wclk),
    .rst   (wrst),
    .d_in  (gray_rd_ptr),
    .d_out (rq2)
  );

  // Full when the write pointer has lapped the read pointer once: top two Gray bits inverted.
  assign full_match = {~rq2[PtrW-1:PtrW-2], rq2[PtrW-3:0]};

  always_comb begin
    full             = (gray_wr_ptr_q == full_match);
    wclken           = winc & ~full;
    wr_ptr_next      = wr_ptr_q + PtrW'(1);
    gray_wr_ptr_next = PtrW'(bin2gray(PTR_MAX_W'(wr_ptr_next)));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wr_ptr_q      <= '0;
      gray_wr_ptr_q <= '0;
    end else if (wclken) begin
      wr_ptr_q      <= wr_ptr_next;
      gray_wr_ptr_q <= gray_wr_ptr_next;
    end
  end

  assign waddr       = wr_ptr_q[ADDR_WIDTH-1:0];
  assign gray_wr_ptr = gray_wr_ptr_q;

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PtrW-1:0] AfTh = PtrW'(ALMOST_FULL_TH);

  logic [PtrW-1:0] rbin;
  logic [PtrW-1:0] wcount;

  // Occupancy uses the stale synchronized read pointer, so it can only over-estimate.
  always_comb begin
    rbin        = PtrW'(gray2bin(PTR_MAX_W'(rq2)));
    wcount      = wr_ptr_q - rbin;
    almost_full = (wcount >= AfTh) | full;
  end
`endif

`ifndef SYNTHESIS
  a_hold_when_full : assert property (@(posedge wclk) disable iff (wrst)
    full |=> $stable(wr_ptr_q));

  a_gray_one_bit : assert property (@(posedge wclk) disable iff (wrst)
    wclken |=> ($countones(gray_wr_ptr_q ^ $past(gray_wr_ptr_q)) == 1));
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: vector table plus hand sequences for reset, wrap and
// almost-full, with expectations queued at drive time and compared before the next edge.
module tb_fifo_wr_ctrl;

  localparam int unsigned AW = 3;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          winc = 1'b1;
  logic [AW:0]   gray_rd_ptr = '0;
  logic [AW-1:0] waddr;
  logic          wclken;
  logic [AW:0]   gray_wr_ptr;
  logic          full;
`ifdef FIFO_WR_ALMOST_FULL_EN
  logic          almost_full;
`endif

  fifo_wr_ctrl #(
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (6)
  ) dut (
    .wclk        (wclk),
    .wrst        (wrst),
    .winc        (winc),
    .gray_rd_ptr (gray_rd_ptr),
    .waddr       (waddr),
    .wclken      (wclken),
    .gray_wr_ptr (gray_wr_ptr),
`ifdef FIFO_WR_ALMOST_FULL_EN
    .full        (full),
    .almost_full (almost_full)
`else
    .full        (full)
`endif
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [AW:0]   gray;
    logic          full;
    logic          wclken;
    logic          af;
    logic          chk_af;
  } exp_t;

  typedef struct packed {
    logic        wrst;
    logic        winc;
    logic [AW:0] rd;
    exp_t        exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [AW:0] fill_g[8] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
  logic [AW:0] prev_gray;

  function automatic logic [AW:0] tb_gray(input int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  function automatic exp_t mk(input int wa, input int g, input logic f, input logic en,
                              input logic af, input logic chk);
    exp_t e;
    e.waddr  = wa[AW-1:0];
    e.gray   = g[AW:0];
    e.full   = f;
    e.wclken = en;
    e.af     = af;
    e.chk_af = chk;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    cmp("waddr", 32'(waddr), 32'(e.waddr));
    cmp("gray_wr_ptr", 32'(gray_wr_ptr), 32'(e.gray));
    cmp("full", 32'(full), 32'(e.full));
    cmp("wclken", 32'(wclken), 32'(e.wclken));
`ifdef FIFO_WR_ALMOST_FULL_EN
    if (e.chk_af) cmp("almost_full", 32'(almost_full), 32'(e.af));
`endif
  endtask

  // Drive at the falling edge, then compare the pre-edge outputs well before the rising edge.
  task automatic apply(input logic r, input logic w, input logic [AW:0] rd, input exp_t e);
    @(negedge wclk);
    wrst        = r;
    winc        = w;
    gray_rd_ptr = rd;
    sb.push_back(e);
    #1;
    check();
  endtask

  initial begin
    // Reset pair with winc high, then fill, overflow and release.
    vecs[0] = '{wrst: 1'b1, winc: 1'b1, rd: 4'd0, exp: mk(0, 0, 0, 1, 0, 1)};
    vecs[1] = '{wrst: 1'b1, winc: 1'b1, rd: 4'd0, exp: mk(0, 0, 0, 1, 0, 1)};
    for (int k = 0; k < 8; k++) begin
      vecs[2+k] = '{wrst: 1'b0, winc: 1'b1, rd: 4'd0,
                    exp: mk(k, int'(fill_g[k]), 0, 1, (k >= 6), 1)};
    end
    for (int k = 10; k < 13; k++) begin
      vecs[k] = '{wrst: 1'b0, winc: 1'b1, rd: 4'd0, exp: mk(0, 12, 1, 0, 1, 1)};
    end
    vecs[13] = '{wrst: 1'b0, winc: 1'b1, rd: 4'd1, exp: mk(0, 12, 1, 0, 1, 1)};
    vecs[14] = '{wrst: 1'b0, winc: 1'b1, rd: 4'd1, exp: mk(0, 12, 1, 0, 1, 1)};
    vecs[15] = '{wrst: 1'b0, winc: 1'b1, rd: 4'd1, exp: mk(0, 12, 0, 1, 1, 1)};
    vecs[16] = '{wrst: 1'b0, winc: 1'b0, rd: 4'd1, exp: mk(1, 13, 1, 0, 1, 1)};

    @(posedge wclk);
    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].wrst, vecs[i].winc, vecs[i].rd, vecs[i].exp);
    end

    // Reset while full drops the pending write; then reset right after a write.
    apply(1'b1, 1'b1, 4'd1, mk(1, 13, 1, 0, 1, 1));
    apply(1'b0, 1'b1, 4'd0, mk(0, 0, 0, 1, 0, 1));
    apply(1'b1, 1'b1, 4'd0, mk(1, 1, 0, 1, 0, 1));
    apply(1'b0, 1'b0, 4'd0, mk(0, 0, 0, 0, 0, 1));

    // Almost-full ramp with the read pointer parked at zero.
    for (int i = 0; i <= 8; i++) begin
      apply(1'b0, (i < 8), 4'd0,
            mk(i % 8, int'(tb_gray(i)), (i == 8), (i < 8), (i >= 6), 1));
    end

    // Wrap: 16 accepted writes with the read pointer trailing one entry behind.
    apply(1'b1, 1'b0, 4'd0, mk(0, 12, 1, 0, 1, 1));
    for (int i = 0; i < 16; i++) begin
      apply(1'b0, 1'b1, tb_gray((i > 0) ? i - 1 : 0),
            mk(i % 8, int'(tb_gray(i)), 0, 1, 0, 0));
      if (i > 0) cmp("gray_one_bit", 32'($countones(gray_wr_ptr ^ prev_gray)), 32'd1);
      prev_gray = gray_wr_ptr;
    end
    apply(1'b0, 1'b0, tb_gray(15), mk(0, 0, 0, 0, 0, 0));
    cmp("gray_one_bit_wrap", 32'($countones(gray_wr_ptr ^ prev_gray)), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
